// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory: FSM state encoding, error-bit positions and word width.
package dmem_pkg;

  localparam int WORD_W = 32;

  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_BUSY  = 2;

  typedef enum logic {
    DMEM_CLEAR = 1'b0,
    DMEM_READY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage with one synchronous write port and one asynchronous read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset port; clearing is done by the owner's sweep so it can map to RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with a post-reset clear sweep and sticky error flags.
// Define DMEM_ACCESS_CNT_EN to add the rd_cnt/wr_cnt accepted-access counters.
module data_mem
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [31:0]       data_addr,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              busy,
  output logic [2:0]        err
`ifdef DMEM_ACCESS_CNT_EN
  , output logic [31:0]     rd_cnt
  , output logic [31:0]     wr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [2:0]    err_q, err_d;

  logic [31:0]       offset;
  logic [AW-1:0]     index;
  logic              in_range, aligned, req, ready;
  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [WORD_W-1:0] arr_wdata, arr_rdata;

  assign offset   = data_addr - BASE_ADDR;
  assign index    = offset[AW+1:2];
  assign in_range = (offset[31:AW+2] == '0);
  assign aligned  = (offset[1:0] == 2'b00);  // BASE_ADDR is word aligned
  assign req      = data_read | data_write;
  assign ready    = (state_q == DMEM_READY);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == DMEM_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == AW'(DEPTH - 1)) state_d = DMEM_READY;
    end
  end

  // The sweep owns the write port while clearing; CPU writes only land when ready.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = index;
    arr_wdata = data_in;
    if (!ready) begin
      arr_we    = 1'b1;
      arr_waddr = clr_idx_q;
      arr_wdata = '0;
    end else if (data_write && in_range) begin
      arr_we = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (req && !in_range) err_d[ERR_RANGE] = 1'b1;
    if (req && !aligned)  err_d[ERR_ALIGN] = 1'b1;
    if (req && !ready)    err_d[ERR_BUSY]  = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DMEM_CLEAR;
      clr_idx_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      err_q     <= err_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (index),
    .rdata (arr_rdata)
  );

  assign data_out = (ready && data_read && in_range) ? arr_rdata : '0;
  assign busy     = ~ready;
  assign err      = err_q;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + 32'(ready && data_read && in_range);
    wr_cnt_d = wr_cnt_q + 32'(ready && data_write && in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem with DEPTH=16; inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_read, data_write;
  logic [31:0] data_addr, data_in, data_out;
  logic        busy;
  logic [2:0]  err;
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_mem #(.DEPTH(16), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_read  (data_read),
    .data_write (data_write),
    .data_addr  (data_addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .busy       (busy),
    .err        (err)
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_cnt   (rd_cnt)
    , .wr_cnt   (wr_cnt)
`endif
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_read  = 1'b0;
    data_write = 1'b0;
    data_addr  = 32'h0;
    data_in    = 32'h0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      cycle();
    end
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #3;
    n_total++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    n_total++;
    if (err !== 3'b000) $display("FAIL reset_err: got %b want 000", err); else n_pass++;
    data_read = 1'b1;
    data_addr = 32'h8;
    #1;
    n_total++;
    if (data_out !== 32'h0) $display("FAIL clear_read: got %h want 0", data_out); else n_pass++;
    #1;
    cycle();
    idle();
    count_busy(cnt);
    n_total++;
    if (cnt !== 15) $display("FAIL busy_len: got %0d want 15 after first clear cycle", cnt); else n_pass++;
    n_total++;
    if (err !== 3'b100) $display("FAIL busy_err: got %b want 100", err); else n_pass++;
  endtask

  task automatic test_write_read();
    data_write = 1'b1;
    data_addr  = 32'h3C;
    data_in    = 32'hDEADBEEF;
    cycle();
    idle();
    data_read = 1'b1;
    data_addr = 32'h3C;
    #3;
    n_total++;
    if (data_out !== 32'hDEADBEEF) $display("FAIL wr_rd_data: got %h want deadbeef", data_out); else n_pass++;
    cycle();
    idle();
    n_total++;
    if (err !== 3'b100) $display("FAIL wr_rd_err: got %b want 100", err); else n_pass++;
`ifdef DMEM_ACCESS_CNT_EN
    n_total++;
    if (wr_cnt !== 32'd1) $display("FAIL wr_cnt: got %0d want 1", wr_cnt); else n_pass++;
    n_total++;
    if (rd_cnt !== 32'd1) $display("FAIL rd_cnt: got %0d want 1", rd_cnt); else n_pass++;
`endif
  endtask

  task automatic test_same_cycle();
    data_write = 1'b1;
    data_addr  = 32'h4;
    data_in    = 32'h11;
    cycle();
    data_read = 1'b1;
    data_in   = 32'h22;
    #3;
    n_total++;
    if (data_out !== 32'h11) $display("FAIL rw_old: got %h want 11", data_out); else n_pass++;
    cycle();
    data_write = 1'b0;
    #3;
    n_total++;
    if (data_out !== 32'h22) $display("FAIL rw_new: got %h want 22", data_out); else n_pass++;
    cycle();
    idle();
  endtask

  task automatic test_out_of_range();
    data_write = 1'b1;
    data_addr  = 32'h40;
    data_in    = 32'h55;
    cycle();
    idle();
    n_total++;
    if (err[0] !== 1'b1) $display("FAIL oor_flag: got %b want 1", err[0]); else n_pass++;
    data_read = 1'b1;
    data_addr = 32'h0;
    #3;
    n_total++;
    if (data_out !== 32'h0) $display("FAIL oor_alias: got %h want 0", data_out); else n_pass++;
    data_addr = 32'h40;
    #1;
    n_total++;
    if (data_out !== 32'h0) $display("FAIL oor_read: got %h want 0", data_out); else n_pass++;
    cycle();
    idle();
  endtask

  task automatic test_misaligned();
    data_write = 1'b1;
    data_addr  = 32'h13;
    data_in    = 32'hA5A5A5A5;
    cycle();
    idle();
    n_total++;
    if (err[1] !== 1'b1) $display("FAIL align_flag: got %b want 1", err[1]); else n_pass++;
    data_read = 1'b1;
    data_addr = 32'h10;
    #3;
    n_total++;
    if (data_out !== 32'hA5A5A5A5) $display("FAIL align_data: got %h want a5a5a5a5", data_out); else n_pass++;
    cycle();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h0000_1111, 32'h2222_0000, 32'hCAFE_F00D};
    data_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_addr = 32'(32 + 4 * i);
      data_in   = vals[i];
      cycle();
    end
    idle();
    data_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_addr = 32'(32 + 4 * i);
      #3;
      n_total++;
      if (data_out !== vals[i]) $display("FAIL b2b_%0d: got %h want %h", i, data_out, vals[i]); else n_pass++;
      cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int cnt;
    data_write = 1'b1;
    data_addr  = 32'h14;
    data_in    = 32'h1234_5678;
    cycle();
    idle();
    data_read = 1'b1;
    data_addr = 32'h14;
    #3;
    n_total++;
    if (data_out !== 32'h1234_5678) $display("FAIL mid_fill: got %h want 12345678", data_out); else n_pass++;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    count_busy(cnt);
    n_total++;
    if (cnt !== 16) $display("FAIL mid_busy_len: got %0d want 16", cnt); else n_pass++;
    n_total++;
    if (err !== 3'b000) $display("FAIL mid_err: got %b want 000", err); else n_pass++;
`ifdef DMEM_ACCESS_CNT_EN
    n_total++;
    if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) $display("FAIL mid_cnt: got %0d/%0d want 0/0", rd_cnt, wr_cnt); else n_pass++;
`endif
    data_read = 1'b1;
    data_addr = 32'h14;
    #3;
    n_total++;
    if (data_out !== 32'h0) $display("FAIL mid_word5: got %h want 0", data_out); else n_pass++;
    cycle();
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_out_of_range();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
